// File: rtl/pcg_permute_pipe.sv
// Two-stage PCG output permutation: XSH-RR, XSL-RR or bypass per word.
// Ports: clk/rst, in_* valid/ready state+mode, out_* valid/ready data, out_count.
module pcg_permute_pipe #(
  parameter int STATE_W = 64,
  parameter int OUT_W   = STATE_W / 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_count
);

  localparam int ROT_BITS = $clog2(OUT_W);
  localparam int XS       = (ROT_BITS + OUT_W) / 2;
  localparam int BASE     = STATE_W - OUT_W - ROT_BITS;

  typedef struct packed {
    logic                valid;
    logic [OUT_W-1:0]    word;
    logic [ROT_BITS-1:0] rot;
    logic                en;
  } s1_t;

  s1_t s1;

  logic                adv;
  logic [OUT_W-1:0]    xsh_w;
  logic [OUT_W-1:0]    pre_w;
  logic [ROT_BITS-1:0] pre_r;
  logic                pre_en;
  logic [OUT_W-1:0]    rot_w;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Xorshift then window at BASE; bits whose partner falls
  // past the top of the state xor with zero.
  for (genvar i = 0; i < OUT_W; i++) begin : g_xsh
    if (BASE + i + XS < STATE_W) begin : g_x
      assign xsh_w[i] = in_state[BASE+i] ^ in_state[BASE+i+XS];
    end else begin : g_p
      assign xsh_w[i] = in_state[BASE+i];
    end
  end

  always_comb begin
    pre_r  = in_state[STATE_W-1 -: ROT_BITS];
    pre_w  = in_state[OUT_W-1:0];
    pre_en = 1'b0;
    unique case (1'b1)
      (in_mode == 2'd0): begin
        pre_w  = xsh_w;
        pre_en = 1'b1;
      end
      (in_mode == 2'd1): begin
        pre_w  = in_state[STATE_W-1:OUT_W]
               ^ in_state[OUT_W-1:0];
        pre_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Bit-select rotate; index wraps mod OUT_W, so r = 0
  // is identity with no over-width shift.
  function automatic logic [OUT_W-1:0] rotr(
    input logic [OUT_W-1:0]    w,
    input logic [ROT_BITS-1:0] r
  );
    logic [ROT_BITS-1:0] k;
    rotr = '0;
    for (int i = 0; i < OUT_W; i++) begin
      k       = ROT_BITS'(i) + r;
      rotr[i] = w[k];
    end
  endfunction

  assign rot_w = s1.en ? rotr(s1.word, s1.rot) : s1.word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s1.valid  <= in_valid;
      s1.word   <= pre_w;
      s1.rot    <= pre_r;
      s1.en     <= pre_en;
      out_valid <= s1.valid;
      out_data  <= rot_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pcg_permute_pipe.sv
// Scoreboard bench for pcg_permute_pipe (defaults plus a CNT_W=4 copy).
// Stimulus pushes expected words; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pcg_permute_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_state;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_count;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [31:0] w_out_data;
  logic [3:0]  w_count;

  always #5 clk = ~clk;

  pcg_permute_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  pcg_permute_pipe #(.CNT_W(4)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_state  (in_state),
    .in_mode   (in_mode),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data),
    .out_count (w_count)
  );

  typedef struct {
    logic [31:0] d;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  bit   bp      = 1'b0;
  bit   chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [63:0] s,
                                        input logic [1:0] m);
    logic [63:0] t;
    logic [31:0] w;
    logic [31:0] o;
    int          r;
    r = int'(s[63:59]);
    if (m == 2'd0) begin
      t = s ^ (s >> 18);
      w = t[58:27];
    end else if (m == 2'd1) begin
      w = s[63:32] ^ s[31:0];
    end else begin
      return s[31:0];
    end
    for (int i = 0; i < 32; i++) o[i] = w[(i + r) % 32];
    return o;
  endfunction

  bit          stall_p = 1'b0;
  logic [31:0] stall_d;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(stall_d));
      end
      if (out_valid && !out_ready)
        check("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_word: got %h expected none", out_data);
        end else begin
          e = q.pop_front();
          check("word", 64'(out_data), 64'(e.d));
          if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
      stall_p = out_valid && !out_ready;
      stall_d = out_data;
    end
  end

  task automatic send(input logic [63:0] s,
                      input logic [1:0]  m,
                      input logic [31:0] exp);
    int n   = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_state = s;
    in_mode  = m;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      if (acc) q.push_back('{d: exp, acc: cyc, lat: chk_lat});
      @(posedge clk);
      #2;
    end
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q.size());
      q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  logic [63:0] bp_tab [10] = '{
    64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
    64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0001,
    64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
    64'h5851_F42D_4C95_7F2D, 64'h1405_7B7E_F767_814F,
    64'hA5A5_5A5A_3C3C_C3C3, 64'h7FFF_0000_FFFF_8001
  };

  initial begin
    logic [63:0] s;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_state = '0;
    in_mode  = '0;

    repeat (4) begin
      @(posedge clk);
      #2;
      in_valid = 1'($urandom);
      in_state = {$urandom, $urandom};
      in_mode  = 2'($urandom);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #2;

    chk_lat = 1'b1;
    send(64'h8000_0000_0000_0000, 2'd0, 32'h0000_0004);
    send(64'h8000_0000_0000_0000, 2'd1, 32'h0000_8000);
    send(64'h1234_5678_9ABC_DEF0, 2'd2, 32'h9ABC_DEF0);
    send(64'h0000_0000_FFFF_0000, 2'd1, 32'hFFFF_0000);
    in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    check("mode_count", 64'(out_count), 64'd4);

    do_reset();
    bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s = bp_tab[i];
      send(s, 2'(i % 4), model(s, 2'(i % 4)));
    end
    in_valid = 1'b0;
    drain();
    bp = 1'b0;
    check("bp_count", 64'(out_count), 64'd10);

    @(posedge clk);
    #2;
    send(64'h0123_4567_89AB_CDEF, 2'd1, 32'h0);
    send(64'hFEDC_BA98_7654_3210, 2'd0, 32'h0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_count", 64'(out_count), 64'd0);
    check("mid_rst_wcount", 64'(w_count), 64'd0);
    q.delete();
    @(posedge clk);
    #2;
    rst = 1'b1;
    chk_lat = 1'b1;
    send(64'h8000_0000_0000_0000, 2'd0, 32'h0000_0004);
    in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    check("post_rst_count", 64'(out_count), 64'd1);

    for (int i = 0; i < 16; i++) begin
      s = {32'(i * 32'h9E37_79B9), 32'(~i * 32'h85EB_CA6B)};
      send(s, 2'(i % 3), model(s, 2'(i % 3)));
    end
    in_valid = 1'b0;
    drain();
    check("wrap_count32", 64'(out_count), 64'd17);
    check("wrap_count4", 64'(w_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
